wave_sample_source: RTL and testbench



---
 rtl/synth_pkg.sv | 44 ++++
 rtl/sample_rate_divider.sv | 38 +++
 rtl/wave_sample_source.sv | 69 ++++++
 tb/tb_wave_sample_source.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synthesiser sample path: waveform codes, DAC format,
// LFSR constants and the waveform shaping helpers.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_SQR   = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_e;

    localparam int unsigned     DAC_W        = 10;
    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 10'd512;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Galois form: shift right, fold the mask back in when a 1 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_MASK;
        end
        return n;
    endfunction

    function automatic logic [DAC_W-1:0] shape(input wave_e            sel,
                                               input logic [DAC_W-1:0] p,
                                               input logic [15:0]      lfsr);
        logic [DAC_W-1:0] ramp;
        logic [DAC_W-1:0] res;
        ramp = {p[DAC_W-2:0], 1'b0};
        unique case (sel)
            WAVE_SAW:   res = p;
            WAVE_SQR:   res = {DAC_W{p[DAC_W-1]}};
            WAVE_TRI:   res = p[DAC_W-1] ? ~ramp : ramp;
            WAVE_NOISE: res = lfsr[DAC_W-1:0];
            default:    res = p;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sample_rate_divider.sv
// Divides clk down to the sample rate: a one-cycle tick at the end of each period and
// a registered square wave high for counts 1..SAMPLE_DIV/2.
module sample_rate_divider #(
    parameter int unsigned SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic sample_clk
);

    localparam int unsigned CntW = $clog2(SAMPLE_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(SAMPLE_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(SAMPLE_DIV / 2);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            sample_clk_q, sample_clk_d;

    always_comb begin
        tick         = (div_cnt_q == CntMax);
        div_cnt_d    = tick ? '0 : div_cnt_q + CntW'(1);
        // Decoded from the next count so the registered output lines up with div_cnt_q.
        sample_clk_d = (div_cnt_d != '0) && (div_cnt_d <= CntHalf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            sample_clk_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            sample_clk_q <= sample_clk_d;
        end
    end

    assign sample_clk = sample_clk_q;

endmodule

// File: rtl/wave_sample_source.sv
// Phase-accumulator oscillator feeding the SPI DAC driver: one new sample per tick,
// held stable for the whole sample period.
module wave_sample_source
    import synth_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned DATA_W     = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [1:0]         wave_sel,
    output logic               sample_clk,
    output logic               sample_strobe,
    output logic [DATA_W-1:0]  data_out
);

    logic tick;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               strobe_q, strobe_d;

    sample_rate_divider #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .sample_clk(sample_clk)
    );

    always_comb begin
        phase_d  = phase_q;
        lfsr_d   = lfsr_q;
        data_d   = data_q;
        strobe_d = tick;
        if (tick) begin
            if (enable) begin
                phase_d = phase_q + freq_word;
            end
            lfsr_d = lfsr_step(lfsr_q);
            // Shape from the updated phase/LFSR so the new sample reflects this tick.
            data_d = enable ? shape(wave_e'(wave_sel), phase_d[PHASE_W-1 -: DAC_W], lfsr_d)
                            : DAC_MIDSCALE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            data_q   <= DAC_MIDSCALE;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign data_out      = data_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_wave_sample_source.sv
// Scoreboard bench for wave_sample_source: directed stimulus queues expected samples,
// a monitor pops one per strobe and checks sample_clk shape and data hold.
module tb_wave_sample_source;

    localparam int unsigned SampleDiv = 8;
    localparam int unsigned PhaseW    = 24;
    localparam int unsigned DataW     = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [PhaseW-1:0] freq_word = '0;
    logic [1:0]        wave_sel = 2'd0;
    logic              sample_clk;
    logic              sample_strobe;
    logic [DataW-1:0]  data_out;

    int checks = 0;
    int errors = 0;
    logic [DataW-1:0] exp_q[$];

    wave_sample_source #(
        .SAMPLE_DIV(SampleDiv),
        .PHASE_W   (PhaseW),
        .DATA_W    (DataW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .sample_clk   (sample_clk),
        .sample_strobe(sample_strobe),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: runs on the falling edge, away from the active edge.
    int               mon_k = 0;
    bit               mon_seen = 1'b0;
    logic [DataW-1:0] mon_last = '0;
    logic [DataW-1:0] mon_exp;

    always @(negedge clk) begin
        if (reset) begin
            mon_seen = 1'b0;
        end else if (sample_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data_out %0d, expected no strobe at %0t",
                         data_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(mon_exp));
            end
            check("sample_clk_at_strobe", 32'(sample_clk), 32'd0);
            mon_k    = 0;
            mon_seen = 1'b1;
            mon_last = data_out;
        end else if (mon_seen) begin
            mon_k++;
            check("sample_clk_shape", 32'(sample_clk),
                  32'((mon_k >= 1) && (mon_k <= int'(SampleDiv / 2))));
            check("data_out_hold", 32'(data_out), 32'(mon_last));
        end
    end

    // Driver actions happen 1 time unit after the falling edge, after the monitor.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int n);
        int got = 0;
        int budget = int'(SampleDiv) * (n + 4);
        while (got < n && budget > 0) begin
            step();
            budget--;
            if (sample_strobe) got++;
        end
        check("strobe_count", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'd512);
        check("rst_sample_clk", 32'(sample_clk), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [DataW-1:0] v);
        exp_q.push_back(v);
    endtask

    initial begin
        int cnt;

        // 1: saw
        enable = 1'b1; wave_sel = 2'd0; freq_word = 24'h010000;
        do_reset();
        push(10'd4); push(10'd8); push(10'd12); push(10'd16);
        wait_strobe(4);

        // 2: square, p = 256, 512, 768, 0, 256, 512
        wave_sel = 2'd1; freq_word = 24'h400000;
        do_reset();
        push(10'd0); push(10'd1023); push(10'd1023); push(10'd0); push(10'd0); push(10'd1023);
        wait_strobe(6);

        // 3: triangle, p = 64 .. 576 in steps of 64
        wave_sel = 2'd2; freq_word = 24'h100000;
        do_reset();
        push(10'd128); push(10'd256); push(10'd384); push(10'd512); push(10'd640);
        push(10'd768); push(10'd896); push(10'd1023); push(10'd895);
        wait_strobe(9);

        // 4: noise, Galois LFSR from 16'hACE1: E270, 7138, 389C, 1C4E
        wave_sel = 2'd3; freq_word = 24'h123456;
        do_reset();
        push(10'd624); push(10'd312); push(10'd156); push(10'd78);
        wait_strobe(4);

        // freq_word = 0 keeps the saw at 0 while strobes continue
        wave_sel = 2'd0; freq_word = 24'h000000;
        do_reset();
        push(10'd0); push(10'd0); push(10'd0);
        wait_strobe(3);

        // 5: mute three cycles before a tick, then resume from the held phase
        wave_sel = 2'd0; freq_word = 24'h010000; enable = 1'b1;
        do_reset();
        push(10'd4); push(10'd8); push(10'd512); push(10'd512); push(10'd12); push(10'd16);
        wait_strobe(2);
        repeat (4) step();
        enable = 1'b0;
        wait_strobe(2);
        enable = 1'b1;
        wait_strobe(2);

        // 6: reset at div_cnt = 5, first strobe 8 cycles after release
        do_reset();
        push(10'd4);
        wait_strobe(1);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("midrst_data_out", 32'(data_out), 32'd512);
        check("midrst_sample_clk", 32'(sample_clk), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) step();
        push(10'd4);
        reset = 1'b0;
        cnt = 0;
        while (!sample_strobe && cnt < 20) begin
            step();
            cnt++;
        end
        check("first_strobe_latency", 32'(cnt), 32'(SampleDiv));

        step();
        reset = 1'b1;
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
